// File: rtl/alu_result_checker.sv
// Receive-side checker for the ALU result path: two-stage valid/ready pipeline
// that checks even parity, decodes op_code to one-hot, and counts beats/errors.
// Define PARITY_ERR_DROP_EN to drop parity-error beats instead of flagging them.
module alu_result_checker #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op_code,
  input  logic [DATA_W-1:0]    in_result,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**OP_W-1:0]   out_func_code,
  output logic [DATA_W-1:0]    out_result,
  output logic                 out_err,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int FUNC_W = 2**OP_W;

  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_result_q, s1_result_d;
  logic              s1_parity_q, s1_parity_d;

  logic              out_valid_q, out_valid_d;
  logic [FUNC_W-1:0] out_func_q, out_func_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic              out_err_q, out_err_d;

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              s2_advance;
  logic              s1_err;
  logic              s2_show;
  logic              s2_err;
  logic [FUNC_W-1:0] func_dec;

  always_comb begin
    s2_advance = !out_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_advance;
    s1_err     = ^{s1_result_q, s1_parity_q};
    func_dec   = '0;
    func_dec[s1_op_q] = 1'b1;
`ifdef PARITY_ERR_DROP_EN
    // Bad beats never occupy stage 2, so the slot stays free for the next one.
    s2_show = s1_valid_q && !s1_err;
    s2_err  = 1'b0;
`else
    s2_show = s1_valid_q;
    s2_err  = s1_err;
`endif
  end

  // Stage 1: capture
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_result_d = s1_result_q;
    s1_parity_d = s1_parity_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d     = in_op_code;
        s1_result_d = in_result;
        s1_parity_d = in_parity;
      end
    end
  end

  // Stage 2: check and output registers
  always_comb begin
    out_valid_d  = out_valid_q;
    out_func_d   = out_func_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    if (s2_advance) begin
      out_valid_d = s2_show;
      if (s2_show) begin
        out_func_d   = func_dec;
        out_result_d = s1_result_q;
        out_err_d    = s2_err;
      end
    end
  end

  // Clear takes priority over any increment in the same cycle.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr_cnt) begin
      beat_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (out_valid_q && out_ready)
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (s2_advance && s1_valid_q && s1_err && (err_cnt_q != {CNT_W{1'b1}}))
        err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_result_q  <= '0;
      s1_parity_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_func_q   <= '0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      beat_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_result_q  <= s1_result_d;
      s1_parity_q  <= s1_parity_d;
      out_valid_q  <= out_valid_d;
      out_func_q   <= out_func_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      beat_cnt_q   <= beat_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_func_code = out_func_q;
  assign out_result    = out_result_q;
  assign out_err       = out_err_q;
  assign beat_cnt      = beat_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed self-checking bench for alu_result_checker (default parameters).
module tb_alu_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op_code;
  logic [3:0] in_result;
  logic       in_parity;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_func_code;
  logic [3:0] out_result;
  logic       out_err;
  logic       clr_cnt;
  logic [7:0] beat_cnt;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_checker #(.DATA_W(4), .OP_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_code(in_op_code), .in_result(in_result), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_func_code(out_func_code), .out_result(out_result), .out_err(out_err),
    .clr_cnt(clr_cnt), .beat_cnt(beat_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] res, input logic good);
    in_valid   = 1'b1;
    in_op_code = op;
    in_result  = res;
    in_parity  = good ? ^res : ~(^res);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [2:0] st_op(input int i);
    return 3'(7 - i);
  endfunction

  function automatic logic [3:0] st_res(input int i);
    return 4'(9 + i);
  endfunction

  initial begin
    logic [7:0] f;
    logic       acc;
    int         idx;

    rst_n = 1'b0; in_valid = 1'b0; in_op_code = '0; in_result = '0; in_parity = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;

    // Reset values
    repeat (3) cyc();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_func", out_func_code, 0);
    check_val("rst_result", out_result, 0);
    check_val("rst_err", out_err, 0);
    check_val("rst_beat_cnt", beat_cnt, 0);
    check_val("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // Single beat, 2-cycle latency
    drive(3'b010, 4'b0010, 1'b1);
    settle();
    check_val("single_in_ready", in_ready, 1);
    check_val("single_parity_bit", in_parity, 1);
    cyc();
    idle();
    settle();
    check_val("single_lat1_valid", out_valid, 0);
    cyc();
    settle();
    check_val("single_valid", out_valid, 1);
    check_val("single_func", out_func_code, 8'h04);
    check_val("single_result", out_result, 4'b0010);
    check_val("single_err", out_err, 0);
    cyc();
    settle();
    check_val("single_beat_cnt", beat_cnt, 1);
    check_val("single_drained", out_valid, 0);
    cyc();

    // Back-to-back op sweep
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(3'(k), 4'(k), 1'b1);
      else idle();
      settle();
      if (k < 8) check_val($sformatf("sweep_in_ready_%0d", k), in_ready, 1);
      if (k >= 2) begin
        f = 8'h01 << (k - 2);
        check_val($sformatf("sweep_valid_%0d", k - 2), out_valid, 1);
        check_val($sformatf("sweep_func_%0d", k - 2), out_func_code, f);
        check_val($sformatf("sweep_result_%0d", k - 2), out_result, 4'(k - 2));
      end
      cyc();
    end
    settle();
    check_val("sweep_err_cnt", err_cnt, 0);
    check_val("sweep_beat_cnt", beat_cnt, 9);
    check_val("sweep_drained", out_valid, 0);
    cyc();

    // Parity error beat
    drive(3'd1, 4'b0111, 1'b0);
    cyc();
    idle();
    cyc();
    settle();
    check_val("perr_err_cnt", err_cnt, 1);
`ifdef PARITY_ERR_DROP_EN
    check_val("perr_dropped", out_valid, 0);
    cyc();
    settle();
    check_val("perr_beat_cnt", beat_cnt, 9);
`else
    check_val("perr_valid", out_valid, 1);
    check_val("perr_flag", out_err, 1);
    check_val("perr_result", out_result, 4'b0111);
    cyc();
    settle();
    check_val("perr_beat_cnt", beat_cnt, 10);
`endif
    check_val("perr_drained", out_valid, 0);
    cyc();

    // Downstream stall with continuous input, then drain
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      drive(st_op(idx), st_res(idx), 1'b1);
      settle();
      check_val($sformatf("stall_in_ready_%0d", k), in_ready, (k < 2) ? 1 : 0);
      if (k >= 2) begin
        f = 8'h01 << st_op(0);
        check_val($sformatf("stall_hold_valid_%0d", k), out_valid, 1);
        check_val($sformatf("stall_hold_func_%0d", k), out_func_code, f);
        check_val($sformatf("stall_hold_result_%0d", k), out_result, st_res(0));
      end
      acc = in_ready;
      cyc();
      if (acc) idx++;
    end
    check_val("stall_accepted", idx, 2);
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (idx < 4) drive(st_op(idx), st_res(idx), 1'b1);
      else idle();
      settle();
      if (r < 4) begin
        f = 8'h01 << st_op(r);
        check_val($sformatf("drain_valid_%0d", r), out_valid, 1);
        check_val($sformatf("drain_func_%0d", r), out_func_code, f);
        check_val($sformatf("drain_result_%0d", r), out_result, st_res(r));
      end else begin
        check_val("drain_empty", out_valid, 0);
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) idx++;
    end

    // Counter clear, err_cnt saturation, beat_cnt wrap
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    settle();
    check_val("clr_beat_cnt", beat_cnt, 0);
    check_val("clr_err_cnt", err_cnt, 0);
    cyc();
    for (int k = 0; k < 260; k++) begin
      drive(3'd3, 4'h1, 1'b0);
      cyc();
    end
    idle();
    cyc();
    cyc();
    settle();
    check_val("sat_err_cnt", err_cnt, 255);
`ifdef PARITY_ERR_DROP_EN
    check_val("sat_beat_cnt", beat_cnt, 0);
`else
    check_val("wrap_beat_cnt", beat_cnt, 4);
`endif
    cyc();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    drive(3'd4, 4'h1, 1'b0);
    cyc();
    idle();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    settle();
    check_val("clrwin_err_cnt", err_cnt, 0);
    check_val("clrwin_beat_cnt", beat_cnt, 0);
    cyc();
    settle();
    check_val("clrwin_err_cnt_after", err_cnt, 0);
    cyc();

    // Reset mid-stream with two beats in flight
    drive(3'd1, 4'h1, 1'b0);
    cyc();
    drive(3'd6, 4'h5, 1'b1);
    cyc();
    idle();
    settle();
    check_val("mid_pre_err_cnt", err_cnt, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_beat_cnt", beat_cnt, 0);
    check_val("mid_rst_err_cnt", err_cnt, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    settle();
    check_val("mid_post_valid", out_valid, 0);
    check_val("mid_post_in_ready", in_ready, 1);
    cyc();
    drive(3'd5, 4'h3, 1'b1);
    cyc();
    idle();
    settle();
    check_val("mid_lat1_valid", out_valid, 0);
    cyc();
    settle();
    check_val("mid_lat2_valid", out_valid, 1);
    check_val("mid_lat2_func", out_func_code, 8'h20);
    check_val("mid_lat2_result", out_result, 4'h3);
    check_val("mid_lat2_err", out_err, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Receive end of the ALU result path. Accepts {op_code, result, parity} beats from the 3-stage encode/ALU/parity pipeline.
- Checks even parity and decodes op_code back to a one-hot func_code.
- Flags errors and keeps beat and error statistics.
- Two-stage registered pipeline with valid/ready handshakes on both sides; sits between the ALU pipeline output and the downstream consumer/scoreboard.

Parameters:
- DATA_W, 4, result width in bits.
- OP_W, 3, op_code width; func_code width is 2**OP_W.
- CNT_W, 8, width of beat and error counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  checker can accept a beat this cycle.
- in_op_code  input  OP_W  op_code of beat.
- in_result  input  DATA_W  ALU result.
- in_parity  input  1  even parity bit generated over in_result.
- out_valid  output  1  checked beat available.
- out_ready  input  1  downstream accepts beat.
- out_func_code  output  2**OP_W  one-hot decoded func_code.
- out_result  output  DATA_W  result passed through.
- out_err  output  1  parity mismatch on this beat.
- clr_cnt  input  1  synchronous clear of both counters.
- beat_cnt  output  CNT_W  beats transferred on output, wrapping.
- err_cnt  output  CNT_W  parity errors detected, saturating.

Behaviour:
- Reset (rst_n low, async): all stage valids 0, in_ready 1 after reset release, out_valid 0, out_func_code 0, out_result 0, out_err 0, beat_cnt 0, err_cnt 0. Reset mid-transfer discards in-flight beats; no partial output.
- Stage 1 (capture): registers op_code, result, parity when in_valid && in_ready.
- Stage 2 (check/output regs):
  - out_func_code = 1 << s1_op_code.
  - out_err = ^{s1_result, s1_parity}; 1 means odd total, i.e. an error.
  - out_result = s1_result.
- Flow control:
  - s2_advance = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_advance. This is combinational from out_ready; no combinational in_valid->in_ready path.
- Stage 1 loads a new beat or clears its valid when s2_advance; it holds when stalled. Stage 2 holds all outputs stable while out_valid && !out_ready.
- Latency: 2 cycles from input handshake to out_valid with no stall. Sustained throughput 1 beat/cycle with out_ready held high.
- Simultaneous input accept and output transfer in one cycle: allowed, no bubble.
- beat_cnt: +1 on each out_valid && out_ready. Wraps from 2**CNT_W-1 to 0.
- err_cnt: +1 when a beat with err=1 loads into stage 2. Saturates at 2**CNT_W-1.
- clr_cnt: clears both counters next edge. An increment in the same cycle is lost (clear wins).
- out_func_code is always exactly one-hot while out_valid=1.

Optional Feature:
- PARITY_ERR_DROP_EN defined: beats with a parity error are counted in err_cnt but never presented. Stage 2 does not set out_valid for them, and the slot frees immediately. beat_cnt counts only good beats; out_err is tied 0.
- Undefined: erroneous beats pass through with out_err=1.

Test Plan:
- Reset then single beat op=3'b010, result=4'b0010, parity=1, out_ready=1 -> out_valid two cycles later, func_code=8'h04, result=4'b0010, err=0, beat_cnt=1.
- Sweep op 0..7 back-to-back, each with correct parity, out_ready=1 -> eight consecutive out_valid cycles, func_code 8'h01..8'h80 in order, in_ready stays 1, err_cnt=0.
- Beat result=4'b0111 with parity=0 -> err=1 and err_cnt=1. With PARITY_ERR_DROP_EN: no out_valid, err_cnt=1, beat_cnt unchanged.
- out_ready=0 for 5 cycles with in_valid=1 continuous -> two beats accepted, then in_ready=0; outputs stable. On release, beats drain in order with no loss or duplication.
- Force 260 parity errors with CNT_W=8 -> err_cnt=255 saturated. Assert clr_cnt coincident with an error beat -> err_cnt=0 next cycle.
- Assert rst_n low mid-stream with 2 beats in flight -> out_valid=0 immediately, counters 0, first post-reset beat emerges with 2-cycle latency.
